// File: rtl/cache_ctrl_dm_if.sv
// Bus bundle for cache_ctrl_dm: CPU request port plus the RAM initiator port.
// The controller uses the slave modport; the CPU/RAM environment uses master.
interface cache_ctrl_dm_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_done;
  logic              cpu_busy;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  cpu_req, cpu_wren, cpu_address, cpu_data, mem_q,
    output cpu_q, cpu_done, cpu_busy, mem_address, mem_data, mem_wren
  );

  modport master (
    output cpu_req, cpu_wren, cpu_address, cpu_data, mem_q,
    input  cpu_q, cpu_done, cpu_busy, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped, write-back, write-allocate cache controller
// sitting between a CPU request port and a 32x8 single-port RAM.
// Optional feature: define CACHE_HIT_COUNT_EN to add saturating
// hit_count/miss_count outputs (counted once per request at its first COMPARE).
module cache_ctrl_dm #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int LINES   = 4,
  parameter int RAM_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  cache_ctrl_dm_if.slave bus
`ifdef CACHE_HIT_COUNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_FILL,
    S_ALLOC
  } state_t;

  state_t state, state_n;

  logic              req_wren;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_data;
  logic [CNT_W-1:0]  fill_cnt;
  logic              refill;

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [DATA_W-1:0] cpu_q_r, cpu_q_n;
  logic              cpu_done_r, cpu_done_n;
  logic              cpu_busy_r, cpu_busy_n;
  logic [ADDR_W-1:0] mem_address_r, mem_address_n;
  logic [DATA_W-1:0] mem_data_r, mem_data_n;
  logic              mem_wren_r, mem_wren_n;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              accept;
  logic              fill_last;

  assign idx       = req_address[IDX_W-1:0];
  assign req_tag   = req_address[ADDR_W-1:IDX_W];
  assign hit       = valid[idx] && (tag_arr[idx] == req_tag);
  assign accept    = (state == S_IDLE) && bus.cpu_req;
  assign fill_last = (fill_cnt == CNT_W'(RAM_LAT - 1));

  assign bus.cpu_q       = cpu_q_r;
  assign bus.cpu_done    = cpu_done_r;
  assign bus.cpu_busy    = cpu_busy_r;
  assign bus.mem_address = mem_address_r;
  assign bus.mem_data    = mem_data_r;
  assign bus.mem_wren    = mem_wren_r;

  // State register; reset abandons any writeback or fill in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and next values of the registered outputs; outputs are set on the way into a state.
  always_comb begin
    state_n       = state;
    cpu_q_n       = cpu_q_r;
    cpu_done_n    = 1'b0;
    cpu_busy_n    = cpu_busy_r;
    mem_address_n = mem_address_r;
    mem_data_n    = mem_data_r;
    mem_wren_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          cpu_busy_n = 1'b1;
          state_n    = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_done_n = 1'b1;
          cpu_busy_n = 1'b0;
          cpu_q_n    = req_wren ? req_data : data_arr[idx];
          state_n    = S_IDLE;
        end else if (valid[idx] && dirty[idx]) begin
          mem_wren_n    = 1'b1;
          mem_address_n = {tag_arr[idx], idx};
          mem_data_n    = data_arr[idx];
          state_n       = S_WRITEBACK;
        end else begin
          mem_address_n = req_address;
          state_n       = S_FILL;
        end
      end
      S_WRITEBACK: begin
        mem_address_n = req_address;
        state_n       = S_FILL;
      end
      S_FILL: begin
        if (fill_last) state_n = S_ALLOC;
      end
      S_ALLOC: begin
        state_n = S_COMPARE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output registers; mem_wren drops the instant reset is asserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_q_r       <= '0;
      cpu_done_r    <= 1'b0;
      cpu_busy_r    <= 1'b0;
      mem_address_r <= '0;
      mem_data_r    <= '0;
      mem_wren_r    <= 1'b0;
    end else begin
      cpu_q_r       <= cpu_q_n;
      cpu_done_r    <= cpu_done_n;
      cpu_busy_r    <= cpu_busy_n;
      mem_address_r <= mem_address_n;
      mem_data_r    <= mem_data_n;
      mem_wren_r    <= mem_wren_n;
    end
  end

  // Capture the accepted request and track whether the next COMPARE is the post-fill re-entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_wren    <= 1'b0;
      req_address <= '0;
      req_data    <= '0;
      refill      <= 1'b0;
    end else begin
      if (accept) begin
        req_wren    <= bus.cpu_wren;
        req_address <= bus.cpu_address;
        req_data    <= bus.cpu_data;
        refill      <= 1'b0;
      end else if (state == S_ALLOC) begin
        refill <= 1'b1;
      end
    end
  end

  // Counts RAM read latency cycles while waiting in FILL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                fill_cnt <= '0;
    else if (state == S_FILL) fill_cnt <= fill_last ? '0 : fill_cnt + CNT_W'(1);
    else                      fill_cnt <= '0;
  end

  // Valid/dirty bookkeeping: allocation leaves the line clean, a write hit marks it dirty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (state == S_ALLOC) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if ((state == S_COMPARE) && hit && req_wren) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clock) begin
    if (state == S_ALLOC) begin
      tag_arr[idx]  <= req_tag;
      data_arr[idx] <= bus.mem_q;
    end else if ((state == S_COMPARE) && hit && req_wren) begin
      data_arr[idx] <= req_data;
    end
  end

`ifdef CACHE_HIT_COUNT_EN
  // Saturating hit/miss counters, bumped only at the first COMPARE of each request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((state == S_COMPARE) && !refill) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
